// File: rtl/bcd_div3_arb.sv
// bcd_div3_arb: two-requester round-robin front end for a sequential
// divisible-by-3 checker on packed-BCD words. One word is in flight at a
// time. It is scanned one digit per cycle, most significant digit first,
// and the result is held until the consumer takes it.
module bcd_div3_arb #(
   parameter int DIGITS = 4,
   localparam int W     = 4 * DIGITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   input  logic [W-1:0] req_bcd0,
   input  logic [W-1:0] req_bcd1,
   output logic [1:0]   req_ready,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic         rsp_div3,
   output logic         rsp_err,
   output logic         busy
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       word_q, word_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         residue_q, residue_d;
   logic               err_q, err_d;
   logic               id_q, id_d;
   logic               rr_last_q, rr_last_d;

   logic [1:0]         grant;
   logic [3:0]         digit;
   logic [2:0]         sum;

   // Digit value mod 3. Non-BCD codes contribute nothing; the word is
   // flagged as an error anyway.
   function automatic logic [1:0] digit_mod3(input logic [3:0] d);
      case (d)
         4'd1, 4'd4, 4'd7: digit_mod3 = 2'd1;
         4'd2, 4'd5, 4'd8: digit_mod3 = 2'd2;
         default:          digit_mod3 = 2'd0;
      endcase
   endfunction

   // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Next-state, datapath and output decode for the IDLE/SCAN/DONE sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d   = state_q;
      word_d    = word_q;
      cnt_d     = cnt_q;
      residue_d = residue_q;
      err_d     = err_q;
      id_d      = id_q;
      rr_last_d = rr_last_q;
      req_ready = 2'b00;
      rsp_valid = 1'b0;
      rsp_id    = 1'b0;
      rsp_div3  = 1'b0;
      rsp_err   = 1'b0;
      busy      = 1'b0;

      digit = word_q[W-1 -: 4];
      sum   = {1'b0, residue_q} + {1'b0, digit_mod3(digit)};

      case (state_q)
         S_IDLE: begin
            // Grant is suppressed while reset is asserted so req_ready reads 00.
            req_ready = rst_n ? grant : 2'b00;
            if (grant != 2'b00) begin
               word_d    = grant[1] ? req_bcd1 : req_bcd0;
               id_d      = grant[1];
               rr_last_d = grant[1];
               residue_d = 2'd0;
               err_d     = 1'b0;
               cnt_d     = '0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            busy      = 1'b1;
            residue_d = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            err_d     = err_q | (digit > 4'd9);
            word_d    = word_q << 4;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            rsp_id    = id_q;
            rsp_div3  = (residue_q == 2'd0) & ~err_q;
            rsp_err   = err_q;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         word_q    <= '0;
         cnt_q     <= '0;
         residue_q <= 2'd0;
         err_q     <= 1'b0;
         id_q      <= 1'b0;
         rr_last_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         word_q    <= word_d;
         cnt_q     <= cnt_d;
         residue_q <= residue_d;
         err_q     <= err_d;
         id_q      <= id_d;
         rr_last_q <= rr_last_d;
      end
   end

endmodule
